controlador_dma: RTL and testbench

Memory-copy/fill engine that acts as the initiator on the `memoriaDados` port, driving its `MemRead`, `MemWrite`, `endereco` and `writeData` inputs and capturing its `readData` output. It sits beside the CPU datapath, which muxes its own data-memory signals with this block's whenever `busy` is high. A single `start` pulse either copies `len` words from `src` to `dst`, or fills `len` words at `dst` with a constant. When the transfer completes, the block raises `done` for one cycle.

---
 rtl/controlador_dma_if.sv | 28 ++
 rtl/controlador_dma.sv | 195 +++++++++++++++++++
 tb/tb_controlador_dma.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_dma_if.sv
// Memory-side bus of the DMA engine: strobes, word address and data in both
// directions. The master drives the memory; the slave is the memory itself.
interface controlador_dma_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) ();
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] endereco;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;

    modport master (
        output MemRead,
        output MemWrite,
        output endereco,
        output writeData,
        input  readData
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  endereco,
        input  writeData,
        output readData
    );
endinterface

// File: rtl/controlador_dma.sv
// Memory copy/fill engine: one start pulse copies or fills up to 2048 words,
// driving the data memory while busy and pulsing done on normal completion.
module controlador_dma #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 modo,
    input  logic [ADDR_W-1:0]    src,
    input  logic [ADDR_W-1:0]    dst,
    input  logic [ADDR_W:0]      len,
    input  logic [DATA_W-1:0]    fillData,
    input  logic                 abort,
    controlador_dma_if.master    mem,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W:0]      contador
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_FILL  = 3'd3,
        ST_FIM   = 3'd4
    } estado_t;

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ZERO_L  = {(ADDR_W+1){1'b0}};

    // Word counts above the memory size collapse to a full-memory transfer.
    function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] l);
        logic [ADDR_W:0] r;
        if (l > LEN_MAX) begin
            r = LEN_MAX;
        end else begin
            r = l;
        end
        return r;
    endfunction

    estado_t             state_r,   state_nxt_s;
    logic                modo_r,    modo_nxt_s;
    logic [ADDR_W-1:0]   src_r,     src_nxt_s;
    logic [ADDR_W-1:0]   dst_r,     dst_nxt_s;
    logic [ADDR_W:0]     len_r,     len_nxt_s;
    logic [DATA_W-1:0]   fill_r,    fill_nxt_s;
    logic [ADDR_W:0]     i_r,       i_nxt_s;
    logic [ADDR_W:0]     cnt_r,     cnt_nxt_s;

    logic                mem_read_r,  mem_read_nxt_s;
    logic                mem_write_r, mem_write_nxt_s;
    logic [ADDR_W-1:0]   endereco_r,  endereco_nxt_s;
    logic [DATA_W-1:0]   wdata_r,     wdata_nxt_s;
    logic                copy_wr_r,   copy_wr_nxt_s;
    logic                busy_r,      busy_nxt_s;
    logic                done_r,      done_nxt_s;
    logic [ADDR_W:0]     len_sat_s;
    logic                last_s;

    assign len_sat_s = sat_len(len);
    assign last_s    = ((i_r + ONE_L) == len_r);

    // Next-state, transfer bookkeeping and next output values.
    always_comb begin
        state_nxt_s = state_r;
        modo_nxt_s  = modo_r;
        src_nxt_s   = src_r;
        dst_nxt_s   = dst_r;
        len_nxt_s   = len_r;
        fill_nxt_s  = fill_r;
        i_nxt_s     = i_r;
        cnt_nxt_s   = cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    modo_nxt_s = modo;
                    src_nxt_s  = src;
                    dst_nxt_s  = dst;
                    len_nxt_s  = len_sat_s;
                    fill_nxt_s = fillData;
                    i_nxt_s    = ZERO_L;
                    cnt_nxt_s  = ZERO_L;
                    if (len_sat_s == ZERO_L) begin
                        state_nxt_s = ST_FIM;
                    end else if (!modo) begin
                        state_nxt_s = ST_READ;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_WRITE, ST_FILL: begin
                // The write of this cycle is issued even when aborting, so it counts.
                i_nxt_s   = i_r + ONE_L;
                cnt_nxt_s = cnt_r + ONE_L;
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_s) begin
                    state_nxt_s = ST_FIM;
                end else if (state_r == ST_WRITE) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_FIM: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        mem_read_nxt_s  = (state_nxt_s == ST_READ);
        mem_write_nxt_s = (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_FILL);
        copy_wr_nxt_s   = (state_nxt_s == ST_WRITE);
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        done_nxt_s      = (state_nxt_s == ST_FIM);

        if (mem_read_nxt_s) begin
            endereco_nxt_s = src_nxt_s + i_nxt_s[ADDR_W-1:0];
        end else if (mem_write_nxt_s) begin
            endereco_nxt_s = dst_nxt_s + i_nxt_s[ADDR_W-1:0];
        end else begin
            endereco_nxt_s = {ADDR_W{1'b0}};
        end

        if (state_nxt_s == ST_FILL) begin
            wdata_nxt_s = fill_nxt_s;
        end else begin
            wdata_nxt_s = {DATA_W{1'b0}};
        end
    end

    // All state and every output strobe are registers, so reset clears them at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            modo_r      <= 1'b0;
            src_r       <= {ADDR_W{1'b0}};
            dst_r       <= {ADDR_W{1'b0}};
            len_r       <= ZERO_L;
            fill_r      <= {DATA_W{1'b0}};
            i_r         <= ZERO_L;
            cnt_r       <= ZERO_L;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            endereco_r  <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            copy_wr_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            modo_r      <= modo_nxt_s;
            src_r       <= src_nxt_s;
            dst_r       <= dst_nxt_s;
            len_r       <= len_nxt_s;
            fill_r      <= fill_nxt_s;
            i_r         <= i_nxt_s;
            cnt_r       <= cnt_nxt_s;
            mem_read_r  <= mem_read_nxt_s;
            mem_write_r <= mem_write_nxt_s;
            endereco_r  <= endereco_nxt_s;
            wdata_r     <= wdata_nxt_s;
            copy_wr_r   <= copy_wr_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    // Copy data passes straight from the memory read port to its write port.
    assign mem.MemRead   = mem_read_r;
    assign mem.MemWrite  = mem_write_r;
    assign mem.endereco  = endereco_r;
    assign mem.writeData = copy_wr_r ? mem.readData : wdata_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign contador      = cnt_r;

endmodule

// File: tb/tb_controlador_dma.sv
// Randomized bench for controlador_dma: a word memory answers the engine and a
// word-level reference model predicts memory contents, timing and counters.
module tb_controlador_dma;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2048;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              start;
    logic              modo;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] fillData;
    logic              abort;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   contador;

    logic              bd_init;
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [DATA_W-1:0] bd_data;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    controlador_dma_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    controlador_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .modo     (modo),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fillData (fillData),
        .abort    (abort),
        .mem      (mem_bus),
        .busy     (busy),
        .done     (done),
        .contador (contador)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] init_word(input int k);
        return (32'(k) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    // Synchronous data memory with one-cycle read latency plus a backdoor port.
    always @(posedge clock) begin
        if (bd_init) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= init_word(k);
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_bus.MemWrite) begin
            mem[mem_bus.endereco] <= mem_bus.writeData;
        end
        if (mem_bus.MemRead) mem_bus.readData <= mem[mem_bus.endereco];
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        @(negedge clock);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        @(negedge clock);
        bd_we = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic check_memory(input string tag);
        int bad = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== ref_mem[k]) bad++;
        check_value(tag, bad, 0);
    endtask

    // One transfer: abort_at is the cycle (1 = first cycle after accept) in which
    // abort is held high, 0 for none.
    task automatic run_xfer(input logic m, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                            input logic [ADDR_W:0] l, input logic [DATA_W-1:0] f,
                            input int abort_at, input bit start_mid, input bit abort_with_start);
        int n, done_c, a, wr_exp, rd_exp, done_exp;
        int c, wr_cnt, rd_cnt, both, done_cnt, done_at, busy_low_at, addr_err, data_err;
        logic busy1;
        logic [ADDR_W-1:0] ea;
        n        = (int'(l) > DEPTH) ? DEPTH : int'(l);
        done_c   = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
        a        = (abort_at == 0 || abort_at > done_c) ? done_c : abort_at;
        wr_exp   = m ? ((a < n) ? a : n) : ((a / 2 < n) ? a / 2 : n);
        rd_exp   = m ? 0 : (((a + 1) / 2 < n) ? (a + 1) / 2 : n);
        done_exp = (a == done_c) ? 1 : 0;
        wr_cnt = 0; rd_cnt = 0; both = 0; done_cnt = 0; done_at = 0;
        busy_low_at = 0; addr_err = 0; data_err = 0; busy1 = 1'b0;

        @(negedge clock);
        start = 1'b1; modo = m; src = s; dst = d; len = l; fillData = f; abort = abort_with_start;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        c = 1;
        while (c <= done_c + 3) begin
            if (c == 1) busy1 = busy;
            if (mem_bus.MemWrite) begin
                ea = d + ADDR_W'(wr_cnt);
                if (mem_bus.endereco !== ea) addr_err++;
                if (m && mem_bus.writeData !== f) data_err++;
                wr_cnt++;
            end
            if (mem_bus.MemRead) begin
                ea = s + ADDR_W'(rd_cnt);
                if (mem_bus.endereco !== ea) addr_err++;
                rd_cnt++;
            end
            if (mem_bus.MemRead && mem_bus.MemWrite) both++;
            if (done) begin done_cnt++; done_at = c; end
            if (!busy && busy_low_at == 0) busy_low_at = c;
            // A second request while busy must leave the running transfer untouched.
            start = (start_mid && c == 1 && a > 2);
            if (start) begin
                modo = ~m; src = s + 11'd77; dst = d + 11'd300; len = 12'd5; fillData = ~f;
            end
            abort = (c == abort_at);
            if (busy_low_at != 0) break;
            @(negedge clock);
            c++;
        end
        start = 1'b0; abort = 1'b0;

        for (int k = 0; k < wr_exp; k++) begin
            if (m) ref_mem[(int'(d) + k) % DEPTH] = f;
            else   ref_mem[(int'(d) + k) % DEPTH] = ref_mem[(int'(s) + k) % DEPTH];
        end

        check_value("busy_cycle1", busy1, 1);
        check_value("done_count", done_cnt, done_exp);
        if (done_exp == 1) check_value("done_cycle", done_at, done_c);
        check_value("busy_low_cycle", busy_low_at, a + 1);
        check_value("write_count", wr_cnt, wr_exp);
        check_value("read_count", rd_cnt, rd_exp);
        check_value("read_write_same_cycle", both, 0);
        check_value("address_sequence", addr_err, 0);
        check_value("fill_data", data_err, 0);
        check_value("contador", contador, wr_exp);
        check_value("idle_endereco", mem_bus.endereco, 0);
        check_value("idle_writeData", mem_bus.writeData, 0);
        check_memory("memory_contents");
    endtask

    initial begin
        int xl;
        logic [DATA_W-1:0] rnd_fill;
        reset_n = 1'b0; start = 1'b0; modo = 1'b0; src = '0; dst = '0; len = '0;
        fillData = '0; abort = 1'b0; bd_init = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = init_word(k);
        @(posedge clock);
        @(negedge clock);
        bd_init = 1'b0;
        check_value("reset_busy", busy, 0);
        check_value("reset_done", done, 0);
        check_value("reset_memread", mem_bus.MemRead, 0);
        check_value("reset_memwrite", mem_bus.MemWrite, 0);
        check_value("reset_endereco", mem_bus.endereco, 0);
        check_value("reset_contador", contador, 0);
        reset_n = 1'b1;

        // Directed scenarios
        run_xfer(1'b1, 11'd0, 11'd100, 12'd4, 32'hA5A5_A5A5, 0, 1'b0, 1'b0);
        poke(11'd10, 32'd1); poke(11'd11, 32'd2); poke(11'd12, 32'd3);
        run_xfer(1'b0, 11'd10, 11'd500, 12'd3, 32'h0, 0, 1'b0, 1'b0);
        run_xfer(1'b1, 11'd0, 11'd2046, 12'd4, 32'h1234_5678, 0, 1'b0, 1'b0);
        run_xfer(1'b0, 11'd2047, 11'd600, 12'd2, 32'h0, 0, 1'b0, 1'b0);
        poke(11'd0, 32'd7);
        run_xfer(1'b0, 11'd0, 11'd1, 12'd3, 32'h0, 0, 1'b0, 1'b0);
        run_xfer(1'b0, 11'd40, 11'd700, 12'd8, 32'h0, 6, 1'b1, 1'b0);
        run_xfer(1'b1, 11'd0, 11'd900, 12'd0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        run_xfer(1'b1, 11'd0, 11'd910, 12'd3, 32'h0BAD_F00D, 0, 1'b0, 1'b1);
        run_xfer(1'b1, 11'd0, 11'd920, 12'd5, 32'h5555_AAAA, 6, 1'b0, 1'b0);

        // Reset in the middle of a fill: nine words land before reset hits.
        @(negedge clock);
        start = 1'b1; modo = 1'b1; dst = 11'd300; len = 12'd50; fillData = 32'hCAFE_0001;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_value("midreset_memwrite", mem_bus.MemWrite, 0);
        check_value("midreset_memread", mem_bus.MemRead, 0);
        check_value("midreset_endereco", mem_bus.endereco, 0);
        check_value("midreset_writeData", mem_bus.writeData, 0);
        check_value("midreset_busy", busy, 0);
        check_value("midreset_contador", contador, 0);
        for (int k = 0; k < 9; k++) ref_mem[300 + k] = 32'hCAFE_0001;
        @(negedge clock);
        reset_n = 1'b1;
        run_xfer(1'b1, 11'd0, 11'd400, 12'd6, 32'h7777_0000, 0, 1'b0, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 40; t++) begin
            int ab, dc;
            if (t % 15 == 14) xl = 2048 + $urandom_range(0, 2047);
            else              xl = $urandom_range(0, 20);
            modo = 1'b0;
            rnd_fill = $urandom;
            dc = (xl > DEPTH) ? DEPTH : xl;
            dc = (dc == 0) ? 1 : ((t % 2 == 1) ? dc + 1 : 2 * dc + 1);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dc) : 0;
            run_xfer(t % 2 == 1, ADDR_W'($urandom), ADDR_W'($urandom), (ADDR_W+1)'(xl), rnd_fill,
                     ab, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
